// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-FU result FIFOs feeding one registered common-data-bus broadcast per cycle.
// Define CDB_ARB_RR_EN for round-robin arbitration; otherwise fixed priority with FU0 highest.
module cdb_arbiter #(
    parameter int N_FU          = 3,
    parameter int FIFO_DEPTH    = 2,
    parameter int ROB_IDX_WIDTH = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [N_FU-1:0]                 fu_valid,
    input  logic [N_FU*32-1:0]              fu_data,
    input  logic [N_FU*5-1:0]               fu_rd_addr,
    input  logic [N_FU*ROB_IDX_WIDTH-1:0]   fu_rob_idx,
    input  logic [N_FU-1:0]                 fu_regf_we,
    output logic [N_FU-1:0]                 fu_ready,
    output logic                            cdb_valid,
    output logic [31:0]                     cdb_data,
    output logic [4:0]                      cdb_rd_addr,
    output logic [ROB_IDX_WIDTH-1:0]        cdb_rob_idx,
    output logic                            cdb_regf_we
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = (N_FU > 1) ? $clog2(N_FU) : 1;
    localparam int ENT_W = 1 + ROB_IDX_WIDTH + 5 + 32;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    // Entry layout: {regf_we, rob_idx, rd_addr, data}
    logic [ENT_W-1:0] mem      [N_FU][FIFO_DEPTH];
    logic [ENT_W-1:0] entry_in [N_FU];
    logic [PTR_W-1:0] rd_ptr   [N_FU];
    logic [PTR_W-1:0] wr_ptr   [N_FU];
    logic [CNT_W-1:0] count    [N_FU];

    logic [N_FU-1:0]  req;
    logic [N_FU-1:0]  push;
    logic [N_FU-1:0]  pop;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic [ENT_W-1:0] head;
    logic             any_req;
    logic [IDX_W-1:0] any_idx;

`ifdef CDB_ARB_RR_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FU - 1);
    logic [IDX_W-1:0] rr_ptr;
    logic             hi_req;
    logic [IDX_W-1:0] hi_idx;
`endif

    // Ready reflects registered occupancy only, so a same-cycle pop never frees space.
    always_comb begin
        fu_ready = '0;
        req      = '0;
        push     = '0;
        for (int i = 0; i < N_FU; i++) begin
            fu_ready[i] = (count[i] < FULL_CNT);
            req[i]      = (count[i] != '0);
            push[i]     = fu_valid[i] & fu_ready[i];
            entry_in[i] = {fu_regf_we[i],
                           fu_rob_idx[i*ROB_IDX_WIDTH +: ROB_IDX_WIDTH],
                           fu_rd_addr[i*5 +: 5],
                           fu_data[i*32 +: 32]};
        end
    end

    // Descending scan: the last hit is the lowest qualifying index.
    always_comb begin
        any_req = 1'b0;
        any_idx = '0;
`ifdef CDB_ARB_RR_EN
        hi_req  = 1'b0;
        hi_idx  = '0;
`endif
        for (int i = N_FU - 1; i >= 0; i--) begin
            if (req[i]) begin
                any_req = 1'b1;
                any_idx = IDX_W'(i);
            end
`ifdef CDB_ARB_RR_EN
            if (req[i] && (IDX_W'(i) >= rr_ptr)) begin
                hi_req = 1'b1;
                hi_idx = IDX_W'(i);
            end
`endif
        end
        grant_valid = any_req;
`ifdef CDB_ARB_RR_EN
        grant_idx   = hi_req ? hi_idx : any_idx;
`else
        grant_idx   = any_idx;
`endif
    end

    always_comb begin
        pop  = '0;
        head = '0;
        for (int i = 0; i < N_FU; i++) begin
            if (grant_valid && (grant_idx == IDX_W'(i))) begin
                pop[i] = 1'b1;
                head   = mem[i][rd_ptr[i]];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_FU; i++) begin
            if (rst || flush) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end else begin
                if (push[i])
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                if (push[i] && !pop[i])
                    count[i] <= count[i] + 1'b1;
                else if (!push[i] && pop[i])
                    count[i] <= count[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_FU; i++) begin
            if (!rst && !flush && push[i])
                mem[i][wr_ptr[i]] <= entry_in[i];
        end
    end

    // Write enable is dropped on idle cycles so consumers ignoring cdb_valid never double-write.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cdb_valid   <= 1'b0;
            cdb_data    <= '0;
            cdb_rd_addr <= '0;
            cdb_rob_idx <= '0;
            cdb_regf_we <= 1'b0;
`ifdef CDB_ARB_RR_EN
            rr_ptr      <= '0;
`endif
        end else begin
            cdb_valid   <= grant_valid;
            cdb_regf_we <= grant_valid & head[ENT_W-1] & (head[36:32] != 5'd0);
            if (grant_valid) begin
                cdb_data    <= head[31:0];
                cdb_rd_addr <= head[36:32];
                cdb_rob_idx <= head[37 +: ROB_IDX_WIDTH];
`ifdef CDB_ARB_RR_EN
                rr_ptr      <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench for cdb_arbiter; a per-FU queue model predicts each broadcast.
// Honours CDB_ARB_RR_EN the same way as the design.
module tb_cdb_arbiter;

    localparam int N_FU       = 3;
    localparam int FIFO_DEPTH = 2;
    localparam int ROB_W      = 5;

    typedef struct packed {
        logic             we;
        logic [ROB_W-1:0] rob;
        logic [4:0]       rd;
        logic [31:0]      data;
    } ent_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic [N_FU-1:0]         fu_valid;
    logic [N_FU*32-1:0]      fu_data;
    logic [N_FU*5-1:0]       fu_rd_addr;
    logic [N_FU*ROB_W-1:0]   fu_rob_idx;
    logic [N_FU-1:0]         fu_regf_we;
    logic [N_FU-1:0]         fu_ready;
    logic                    cdb_valid;
    logic [31:0]             cdb_data;
    logic [4:0]              cdb_rd_addr;
    logic [ROB_W-1:0]        cdb_rob_idx;
    logic                    cdb_regf_we;

    cdb_arbiter #(.N_FU(N_FU), .FIFO_DEPTH(FIFO_DEPTH), .ROB_IDX_WIDTH(ROB_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fu_valid(fu_valid), .fu_data(fu_data), .fu_rd_addr(fu_rd_addr),
        .fu_rob_idx(fu_rob_idx), .fu_regf_we(fu_regf_we), .fu_ready(fu_ready),
        .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_rd_addr(cdb_rd_addr),
        .cdb_rob_idx(cdb_rob_idx), .cdb_regf_we(cdb_regf_we)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    ent_t            mq [N_FU][$];
    ent_t            exp_q[$];
    int              seen[$];
    int              rr = 0;
    bit              clear_flag = 1'b0;
    logic [N_FU-1:0] accepted = '0;
    logic [N_FU-1:0] stream_en = '0;
    int              seq [N_FU];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end else begin
            passes++;
        end
    endtask

    task automatic applyStimulus(input int fu, input logic v, input logic [31:0] d,
                                 input logic [4:0] rd, input logic [ROB_W-1:0] rob, input logic we);
        fu_valid[fu]               = v;
        fu_data[fu*32 +: 32]       = d;
        fu_rd_addr[fu*5 +: 5]      = rd;
        fu_rob_idx[fu*ROB_W +: ROB_W] = rob;
        fu_regf_we[fu]             = we;
    endtask

    task automatic idleAll();
        for (int i = 0; i < N_FU; i++)
            applyStimulus(i, 1'b0, 32'h0, 5'd0, '0, 1'b0);
    endtask

    task automatic streamNext(input int fu);
        seq[fu]++;
        applyStimulus(fu, 1'b1, {4'(fu), 12'h0, 16'(seq[fu])}, 5'(seq[fu]), 5'(seq[fu] + fu), 1'b1);
    endtask

    // Reference behaviour for one clock edge, using the pre-edge model occupancy.
    task automatic modelEdge();
        int              g;
        int              idx;
        logic [N_FU-1:0] rdy;
        ent_t            e;
        accepted = '0;
        if (rst || flush) begin
            for (int i = 0; i < N_FU; i++) mq[i].delete();
            exp_q.delete();
            rr = 0;
            clear_flag = 1'b1;
            return;
        end
        clear_flag = 1'b0;
        for (int i = 0; i < N_FU; i++) rdy[i] = (mq[i].size() < FIFO_DEPTH);
        g = -1;
`ifdef CDB_ARB_RR_EN
        for (int k = 0; k < N_FU; k++) begin
            idx = (rr + k) % N_FU;
            if (g < 0 && mq[idx].size() != 0) g = idx;
        end
`else
        for (int i = 0; i < N_FU; i++)
            if (g < 0 && mq[i].size() != 0) g = i;
`endif
        if (g >= 0) begin
            e = mq[g].pop_front();
            exp_q.push_back(e);
            rr = (g + 1) % N_FU;
        end
        for (int i = 0; i < N_FU; i++) begin
            if (fu_valid[i] && rdy[i]) begin
                e.data = fu_data[i*32 +: 32];
                e.rd   = fu_rd_addr[i*5 +: 5];
                e.rob  = fu_rob_idx[i*ROB_W +: ROB_W];
                e.we   = fu_regf_we[i];
                mq[i].push_back(e);
                accepted[i] = 1'b1;
            end
        end
    endtask

    task automatic step();
        ent_t            e;
        logic            exp_v;
        logic [N_FU-1:0] mrdy;
        @(posedge clk);
        modelEdge();
        #1;
        exp_v = (exp_q.size() != 0);
        e = '0;
        if (exp_v) e = exp_q.pop_front();
        checkOutput("cdb_valid", cdb_valid, exp_v);
        if (cdb_valid && exp_v) begin
            checkOutput("cdb_data", cdb_data, e.data);
            checkOutput("cdb_rd_addr", cdb_rd_addr, e.rd);
            checkOutput("cdb_rob_idx", cdb_rob_idx, e.rob);
            checkOutput("cdb_regf_we", cdb_regf_we, e.we && (e.rd != 5'd0));
        end
        if (clear_flag) begin
            checkOutput("clr_data", cdb_data, 0);
            checkOutput("clr_rd", cdb_rd_addr, 0);
            checkOutput("clr_rob", cdb_rob_idx, 0);
            checkOutput("clr_we", cdb_regf_we, 0);
        end
        for (int i = 0; i < N_FU; i++) mrdy[i] = (mq[i].size() < FIFO_DEPTH);
        checkOutput("fu_ready", fu_ready, mrdy);
        if (cdb_valid) seen.push_back(int'(cdb_data[31:28]));
        for (int i = 0; i < N_FU; i++)
            if (stream_en[i] && accepted[i]) streamNext(i);
    endtask

    task automatic checkOrder(input string tag);
        checkOutput({tag, "_len"}, seen.size(), 3);
        for (int k = 0; k < 3 && k < seen.size(); k++)
            checkOutput(tag, seen[k], k);
    endtask

    task automatic singleScenario(input string tag);
        applyStimulus(0, 1'b1, 32'h0000_00AA, 5'd5, 5'd3, 1'b1);
        step();
        idleAll();
        step();
        checkOutput({tag, "_valid"}, cdb_valid, 1);
        checkOutput({tag, "_data"}, cdb_data, 32'hAA);
        checkOutput({tag, "_rd"}, cdb_rd_addr, 5);
        checkOutput({tag, "_rob"}, cdb_rob_idx, 3);
        checkOutput({tag, "_we"}, cdb_regf_we, 1);
        step();
        checkOutput({tag, "_valid_end"}, cdb_valid, 0);
    endtask

    initial begin
        for (int i = 0; i < N_FU; i++) seq[i] = 0;
        rst = 1'b1;
        flush = 1'b0;
        fu_valid = '0; fu_data = '0; fu_rd_addr = '0; fu_rob_idx = '0; fu_regf_we = '0;
        step();
        step();
        checkOutput("rst_ready", fu_ready, 3'b111);
        rst = 1'b0;

        $display("[TB] single result");
        singleScenario("single");

        $display("[TB] x0 destination");
        applyStimulus(1, 1'b1, 32'h1000_0077, 5'd0, 5'd9, 1'b1);
        step();
        idleAll();
        step();
        checkOutput("x0_valid", cdb_valid, 1);
        checkOutput("x0_we", cdb_regf_we, 0);
        checkOutput("x0_rob", cdb_rob_idx, 9);
        step();

        $display("[TB] contention");
        for (int round = 0; round < 2; round++) begin
            for (int i = 0; i < N_FU; i++)
                applyStimulus(i, 1'b1, {4'(i), 28'h0C0 + 28'(round)}, 5'(i + 1), 5'(10 + 3*round + i), 1'b1);
            step();
            idleAll();
            seen.delete();
            repeat (3) step();
            checkOrder(round == 0 ? "order_r0" : "order_r1");
            step();
        end

        $display("[TB] back-pressure");
        streamNext(0);
        streamNext(2);
        stream_en = 3'b101;
        step();
        step();
`ifndef CDB_ARB_RR_EN
        checkOutput("bp_ready2", fu_ready[2], 0);
`endif
        repeat (6) step();
        stream_en[0] = 1'b0;
        applyStimulus(0, 1'b0, 32'h0, 5'd0, '0, 1'b0);
        repeat (4) step();
        stream_en = '0;
        idleAll();
        repeat (6) step();

        $display("[TB] flush");
        applyStimulus(0, 1'b1, 32'h0000_0F01, 5'd1, 5'd20, 1'b1);
        applyStimulus(2, 1'b1, 32'h2000_0F02, 5'd2, 5'd21, 1'b1);
        step();
        applyStimulus(0, 1'b1, 32'h0000_0F03, 5'd3, 5'd22, 1'b1);
        applyStimulus(1, 1'b1, 32'h1000_0F04, 5'd4, 5'd23, 1'b1);
        applyStimulus(2, 1'b1, 32'h2000_0F05, 5'd5, 5'd24, 1'b1);
        step();
        checkOutput("pre_flush_valid", cdb_valid, 1);
        applyStimulus(2, 1'b0, 32'h0, 5'd0, '0, 1'b0);
        applyStimulus(1, 1'b1, 32'h1000_0F06, 5'd6, 5'd25, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idleAll();
        checkOutput("flush_ready", fu_ready, 3'b111);
        for (int k = 0; k < 3; k++) begin
            step();
            checkOutput("flush_valid", cdb_valid, 0);
        end

        $display("[TB] reset mid-operation");
        stream_en = 3'b111;
        for (int i = 0; i < N_FU; i++) streamNext(i);
        repeat (4) step();
        checkOutput("pre_rst_valid", cdb_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        stream_en = '0;
        idleAll();
        checkOutput("midrst_valid", cdb_valid, 0);
        checkOutput("midrst_ready", fu_ready, 3'b111);
        singleScenario("post_rst");

        repeat (3) step();
        checkOutput("sb_empty", exp_q.size(), 0);
        for (int i = 0; i < N_FU; i++)
            checkOutput("model_fifo_empty", mq[i].size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
